// File: rtl/decode_stage_pkg.sv
// Shared ISA constants, destination-select encodings and decode-stage types.
// Imported by the register file and the decode stage itself.
package decode_stage_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int RW   = 3;

  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;
  localparam int RD_HI = 4;
  localparam int RD_LO = 2;

  localparam logic [RW-1:0] R7 = 3'd7;

  typedef enum logic [1:0] {
    DST_RD = 2'b00,
    DST_RT = 2'b01,
    DST_RS = 2'b10,
    DST_R7 = 2'b11
  } reg_dst_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // One in-flight writer: slot0 tracks EX, slot1 tracks MEM.
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rg;
  } slot_t;

  typedef struct packed {
    state_e state;
    slot_t  slot0;
    slot_t  slot1;
  } dbg_t;

  function automatic logic slot_hit(slot_t s, logic [RW-1:0] r);
    return s.valid && (s.rg == r);
  endfunction

endpackage

// File: rtl/decode_stage_regfile_bypass.sv
// 8x16 register file, two combinational read ports, one write port.
// A same-cycle writeback to the read index is returned directly.
module regfile_bypass
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] ra1,
  input  logic [RW-1:0] ra2,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_reg] <= wb_data;
    end
  end

  assign rd1 = (wb_en && (wb_reg == ra1)) ? wb_data : regs[ra1];
  assign rd2 = (wb_en && (wb_reg == ra2)) ? wb_data : regs[ra2];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read with WB bypass, immediate extension, and a
// two-slot scoreboard that stalls IF/ID on RAW hazards (no forwarding).
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr,
  input  logic          instr_valid,
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic [1:0]    RegDst,
  input  logic          RegWrt_in,
  input  logic          ZeroExt,
  input  logic          halt_in,
  input  logic          flush,
  input  logic          mem_stall,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] ReadData1,
  output logic [DW-1:0] ReadData2,
  output logic [DW-1:0] fourExtend,
  output logic [DW-1:0] sevenExtend,
  output logic [DW-1:0] shifted,
  output logic [DW-1:0] word_align_jump,
  output logic [RW-1:0] write_reg,
  output logic          SendNOP,
  output logic          stall,
  output logic          halted,
  output dbg_t          dbg
);

  logic [RW-1:0] rs, rt, rd;
  slot_t         slot0, slot1;
  state_e        state, state_nxt;
  logic          hz, issue;

  assign rs = instr[RS_HI:RS_LO];
  assign rt = instr[RT_HI:RT_LO];
  assign rd = instr[RD_HI:RD_LO];

  regfile_bypass u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra1     (rs),
    .ra2     (rt),
    .wb_en   (wb_en),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .rd1     (ReadData1),
    .rd2     (ReadData2)
  );

  always_comb begin
    write_reg = rd;
    case (reg_dst_e'(RegDst))
      DST_RD:  write_reg = rd;
      DST_RT:  write_reg = rt;
      DST_RS:  write_reg = rs;
      DST_R7:  write_reg = R7;
      default: write_reg = rd;
    endcase
  end

  assign fourExtend      = ZeroExt ? {11'b0, instr[4:0]} : {{11{instr[4]}}, instr[4:0]};
  assign sevenExtend     = ZeroExt ? {8'b0, instr[7:0]}  : {{8{instr[7]}}, instr[7:0]};
  assign shifted         = {8'h00, instr[7:0]};
  assign word_align_jump = {{5{instr[10]}}, instr[10:0]};

  // Contract with IF/ID and ID/EX: stall holds IF/ID and the PC; SendNOP makes
  // ID/EX capture a bubble. An instruction moves on only when issue is high.
  always_comb begin
    hz = instr_valid &&
         ((use_rs && (slot_hit(slot0, rs) || slot_hit(slot1, rs))) ||
          (use_rt && (slot_hit(slot0, rt) || slot_hit(slot1, rt))));
    issue   = instr_valid && !hz && !flush && (state == ST_RUN) && !rst;
    SendNOP = !issue || rst;
    stall   = !rst && ((state == ST_HALTED) || (hz && !flush));
    halted  = !rst && (state == ST_HALTED);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (issue && halt_in && !mem_stall) state_nxt = ST_HALTED;
      ST_HALTED: if (flush && !mem_stall)            state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Wrong-path or stalled instructions enter EX as bubbles, so slot0 is invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (!mem_stall) begin
      slot1 <= slot0;
      slot0 <= '{valid: issue && RegWrt_in, rg: write_reg};
    end
  end

  assign dbg = '{state: state, slot0: slot0, slot1: slot1};

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: extension table, directed hazard/halt sequences,
// and randomized cycles against an in-flight-list reference model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int W = 102;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid, use_rs, use_rt;
  logic [1:0]  RegDst;
  logic        RegWrt_in, ZeroExt, halt_in, flush, mem_stall, wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic [15:0] ReadData1, ReadData2, fourExtend, sevenExtend, shifted, word_align_jump;
  logic [2:0]  write_reg;
  logic        SendNOP, stall, halted;
  dbg_t        dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  logic [15:0] m_regs [8];
  int          m_inflight[$];
  bit          m_halted;

  logic [15:0] c_rd1, c_rd2, c_four, c_seven, c_wj;
  logic        c_sendnop, c_stall, c_halted;
  dbg_t        c_dbg;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .use_rs(use_rs), .use_rt(use_rt), .RegDst(RegDst), .RegWrt_in(RegWrt_in),
    .ZeroExt(ZeroExt), .halt_in(halt_in), .flush(flush), .mem_stall(mem_stall),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .fourExtend(fourExtend),
    .sevenExtend(sevenExtend), .shifted(shifted), .word_align_jump(word_align_jump),
    .write_reg(write_reg), .SendNOP(SendNOP), .stall(stall), .halted(halted), .dbg(dbg)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ext(int v, int bits, bit zx);
    int m;
    m = v & ((1 << bits) - 1);
    if (!zx && m >= (1 << (bits - 1))) m -= (1 << bits);
    return m[15:0];
  endfunction

  function automatic bit in_flight(int r);
    foreach (m_inflight[k]) if (m_inflight[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void clear_inputs();
    rst = 0; instr = '0; instr_valid = 0; use_rs = 0; use_rt = 0; RegDst = 2'b00;
    RegWrt_in = 0; ZeroExt = 0; halt_in = 0; flush = 0; mem_stall = 0;
    wb_en = 0; wb_reg = '0; wb_data = '0;
  endfunction

  function automatic void set_instr(int rs, int rt, int rd, bit urs, bit urt, bit wr);
    instr = 16'((rs << 8) | (rt << 5) | (rd << 2));
    instr_valid = 1; use_rs = urs; use_rt = urt; RegDst = 2'b00; RegWrt_in = wr;
  endfunction

  // One clock: compare at negedge against the model, then advance the model.
  task automatic tick();
    int rs, rt, rd, wr;
    bit hz, iss, exp_stall, exp_halted;
    logic [15:0] e1, e2, a1, a2;
    logic [W-1:0] exp_v, act_v;
    @(negedge clk);
    rs = int'(instr[10:8]); rt = int'(instr[7:5]); rd = int'(instr[4:2]);
    case (RegDst)
      2'b00: wr = rd;
      2'b01: wr = rt;
      2'b10: wr = rs;
      default: wr = 7;
    endcase
    hz = instr_valid && ((use_rs && in_flight(rs)) || (use_rt && in_flight(rt)));
    iss = !rst && instr_valid && !hz && !flush && !m_halted;
    exp_stall  = !rst && (m_halted || (hz && !flush));
    exp_halted = !rst && m_halted;
    e1 = (wb_en && int'(wb_reg) == rs) ? wb_data : m_regs[rs];
    e2 = (wb_en && int'(wb_reg) == rt) ? wb_data : m_regs[rt];
    a1 = ReadData1; a2 = ReadData2;
    if (rst) begin e1 = '0; e2 = '0; a1 = '0; a2 = '0; end
    exp_v = {e1, e2, ext(int'(instr), 5, ZeroExt), ext(int'(instr), 8, ZeroExt),
             16'(int'(instr) & 255), ext(int'(instr), 11, 1'b0), 3'(wr),
             !iss, exp_stall, exp_halted};
    act_v = {a1, a2, fourExtend, sevenExtend, shifted, word_align_jump, write_reg,
             SendNOP, stall, halted};
    exp_q.push_back(exp_v);
    check("model", act_v, exp_q.pop_front());
    c_rd1 = ReadData1; c_rd2 = ReadData2; c_four = fourExtend; c_seven = sevenExtend;
    c_wj = word_align_jump; c_sendnop = SendNOP; c_stall = stall; c_halted = halted;
    c_dbg = dbg;
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[k]) m_regs[k] = '0;
      m_inflight = '{-1, -1};
      m_halted = 0;
    end else begin
      if (wb_en) m_regs[wb_reg] = wb_data;
      if (!mem_stall) begin
        m_inflight.push_front((iss && RegWrt_in) ? wr : -1);
        void'(m_inflight.pop_back());
        if (!m_halted && iss && halt_in) m_halted = 1;
        else if (m_halted && flush) m_halted = 0;
      end
    end
    #1;
  endtask

  task automatic count_stalls(output int n, output bit issued);
    n = 0; issued = 0;
    for (int k = 0; k < 8 && !issued; k++) begin
      tick();
      if (!c_sendnop) issued = 1;
      else if (c_stall) n++;
    end
  endtask

  task automatic drain();
    clear_inputs();
    repeat (3) tick();
  endtask

  typedef struct {
    logic [15:0] instr;
    bit          zx;
    logic [15:0] four, seven, wj;
  } ext_vec_t;

  ext_vec_t vecs[8];

  initial begin
    int n;
    bit issued;
    vecs[0] = '{16'h001F, 1'b0, 16'hFFFF, 16'h001F, 16'h001F};
    vecs[1] = '{16'h001F, 1'b1, 16'h001F, 16'h001F, 16'h001F};
    vecs[2] = '{16'h0400, 1'b0, 16'h0000, 16'h0000, 16'hFC00};
    vecs[3] = '{16'h0080, 1'b0, 16'h0000, 16'hFF80, 16'h0080};
    vecs[4] = '{16'h0080, 1'b1, 16'h0000, 16'h0080, 16'h0080};
    vecs[5] = '{16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[6] = '{16'hFBEF, 1'b1, 16'h000F, 16'h00EF, 16'h03EF};
    vecs[7] = '{16'h1234, 1'b0, 16'hFFF4, 16'h0034, 16'h0234};

    clear_inputs();
    m_inflight = '{-1, -1};
    m_halted = 0;
    foreach (m_regs[k]) m_regs[k] = '0;

    rst = 1;
    tick(); tick();
    check("rst_outputs", {31'b0, c_sendnop, c_stall, c_halted}, 34'b100);
    rst = 0;

    set_instr(3, 0, 0, 1, 0, 0);
    tick();
    check("r3_after_reset", 102'(c_rd1), 102'(16'h0000));
    wb_en = 1; wb_reg = 3; wb_data = 16'hBEEF;
    tick();
    check("r3_bypass", 102'(c_rd1), 102'(16'hBEEF));
    wb_en = 0;
    tick();
    check("r3_stored", 102'(c_rd1), 102'(16'hBEEF));

    wb_en = 1; wb_reg = 0; wb_data = 16'h1234;
    instr_valid = 0;
    tick();
    wb_en = 0;
    set_instr(0, 0, 0, 1, 0, 0);
    tick();
    check("r0_writable", 102'(c_rd1), 102'(16'h1234));

    clear_inputs();
    foreach (vecs[i]) begin
      instr = vecs[i].instr; ZeroExt = vecs[i].zx;
      tick();
      check($sformatf("ext_vec%0d", i), {54'b0, c_four, c_seven, c_wj},
            {54'b0, vecs[i].four, vecs[i].seven, vecs[i].wj});
    end

    drain();
    set_instr(0, 0, 2, 0, 0, 1);
    tick();
    check("writer_issues", 102'(c_sendnop), 102'(0));
    set_instr(2, 0, 1, 1, 0, 0);
    count_stalls(n, issued);
    check("raw_slot0_stalls", {101'(n), issued}, {101'(2), 1'b1});

    drain();
    set_instr(0, 0, 5, 0, 0, 1); tick();
    set_instr(1, 1, 1, 0, 0, 0); tick();
    set_instr(5, 0, 1, 1, 0, 0);
    count_stalls(n, issued);
    check("raw_slot1_stalls", {101'(n), issued}, {101'(1), 1'b1});

    drain();
    set_instr(0, 4, 0, 0, 0, 1); RegDst = 2'b01; tick();
    set_instr(1, 1, 1, 0, 0, 0); tick();
    tick();
    set_instr(0, 4, 1, 0, 1, 0);
    count_stalls(n, issued);
    check("raw_wb_no_stall", {101'(n), issued}, {101'(0), 1'b1});

    drain();
    set_instr(0, 0, 6, 0, 0, 1); tick();
    set_instr(6, 0, 1, 1, 0, 1); flush = 1;
    tick();
    check("flush_over_hazard", {100'b0, c_stall, c_sendnop}, {100'b0, 1'b0, 1'b1});
    flush = 0;
    tick();
    check("flush_not_recorded", {100'b0, c_dbg.slot0.valid, c_stall}, {100'b0, 1'b0, 1'b1});
    count_stalls(n, issued);
    check("flush_then_issue", {101'(n), issued}, {101'(0), 1'b1});

    drain();
    set_instr(0, 0, 2, 0, 0, 1); tick();
    set_instr(2, 0, 1, 1, 0, 0); mem_stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mem_stall_holds", {100'b0, c_stall, c_sendnop}, {100'b0, 1'b1, 1'b1});
    end
    mem_stall = 0;
    count_stalls(n, issued);
    check("mem_stall_resume", {101'(n), issued}, {101'(2), 1'b1});

    drain();
    set_instr(0, 0, 3, 0, 0, 1); tick();
    set_instr(3, 0, 1, 1, 0, 0); tick();
    check("pre_rst_stall", 102'(c_stall), 102'(1));
    rst = 1; tick();
    check("rst_mid_stall", {100'b0, c_sendnop, c_stall}, {100'b0, 1'b1, 1'b0});
    rst = 0; tick();
    check("after_rst_issue", {100'b0, c_sendnop, c_stall}, {100'b0, 1'b0, 1'b0});

    drain();
    set_instr(1, 1, 1, 0, 0, 0); halt_in = 1; tick();
    check("halt_issues", {100'b0, c_sendnop, c_halted}, {100'b0, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halted_frozen", {99'b0, c_halted, c_sendnop, c_stall}, {99'b0, 3'b111});
    end
    flush = 1; tick(); flush = 0; halt_in = 0;
    set_instr(1, 1, 1, 0, 0, 0); tick();
    check("halt_released", {100'b0, c_halted, c_sendnop}, {100'b0, 1'b0, 1'b0});

    for (int k = 0; k < 1500; k++) begin
      rst         = ($urandom_range(0, 150) == 0);
      instr       = 16'($urandom);
      instr[10:8] = 3'($urandom_range(0, 3));
      instr[7:5]  = 3'($urandom_range(0, 3));
      instr[4:2]  = 3'($urandom_range(0, 3));
      instr_valid = ($urandom_range(0, 9) != 0);
      use_rs      = 1'($urandom);
      use_rt      = 1'($urandom);
      RegDst      = 2'($urandom);
      RegWrt_in   = 1'($urandom);
      ZeroExt     = 1'($urandom);
      halt_in     = ($urandom_range(0, 40) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      mem_stall   = ($urandom_range(0, 7) == 0);
      wb_en       = 1'($urandom);
      wb_reg      = 3'($urandom_range(0, 3));
      wb_data     = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
